display_scan: RTL

DISPLAY_SCAN -- requirements
Module: display_scan

---
 rtl/display_pkg.sv | 38 +++
 rtl/display_scan_if.sv | 21 ++
 rtl/bcd_to_seg7.sv | 27 ++
 rtl/display_scan.sv | 115 +++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// Shared constants for the multiplexed 6-digit clock display:
// active-low segment patterns and the blink field selector.
package display_pkg;

    localparam int NUM_DIGITS = 6;

    // Segment patterns are {g,f,e,d,c,b,a}, active-low
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_DASH  = 7'h3F;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    typedef enum logic [1:0] {
        BLINK_NONE = 2'b00,
        BLINK_SEC  = 2'b01,
        BLINK_MIN  = 2'b10,
        BLINK_HOUR = 2'b11
    } blink_sel_e;

    // Which time field a digit slot belongs to (two digits per field)
    function automatic blink_sel_e field_of_digit(input logic [2:0] idx);
        case (idx)
            3'd0, 3'd1: return BLINK_SEC;
            3'd2, 3'd3: return BLINK_MIN;
            3'd4, 3'd5: return BLINK_HOUR;
            default:    return BLINK_NONE;
        endcase
    endfunction

endpackage

// File: rtl/display_scan_if.sv
// Signal bundle for the display scanner: time/blink inputs from the
// clock core and the multiplexed digit/segment drive going to the panel.
interface display_scan_if;
    logic [7:0] hour;
    logic [7:0] min;
    logic [7:0] sec;
    logic [1:0] blink_sel;
    logic [7:0] an;
    logic [6:0] seg;
    logic       dp;

    modport master (
        output hour, min, sec, blink_sel,
        input  an, seg, dp
    );

    modport slave (
        input  hour, min, sec, blink_sel,
        output an, seg, dp
    );
endinterface

// File: rtl/bcd_to_seg7.sv
// Combinational BCD nibble to active-low 7-segment pattern; any
// non-decimal nibble is rendered as a dash.
module bcd_to_seg7
    import display_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_DASH;
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/display_scan.sv
// Six-digit multiplexed HH.MM.SS display driver with per-frame time
// snapshot (no tearing) and selectable field blinking.
module display_scan
    import display_pkg::*;
#(
    parameter int SCAN_DIV     = 100000,
    parameter int BLINK_FRAMES = 250
) (
    input  logic       CP,
    input  logic       CLR,
    input  logic [7:0] hour,
    input  logic [7:0] min,
    input  logic [7:0] sec,
    input  logic [1:0] blink_sel,
    output logic [7:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    localparam int PRE_W   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int FRAME_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [PRE_W-1:0]   PRE_LAST   = PRE_W'(SCAN_DIV - 1);
    localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(BLINK_FRAMES - 1);

    logic [PRE_W-1:0]   pre_reg;
    logic [2:0]         index_reg;
    logic [FRAME_W-1:0] frame_reg;
    logic               phase_reg;
    logic [23:0]        snap_reg;
    logic [7:0]         an_reg;
    logic [6:0]         seg_reg;
    logic               dp_reg;

    logic [7:0] an_next;
    logic [6:0] seg_next;
    logic       dp_next;
    logic       tick;
    logic       frame_end;
    logic       blank;
    logic [3:0] digit [8];
    logic [3:0] cur_digit;

    assign tick      = (pre_reg == PRE_LAST);
    assign frame_end = tick && (index_reg == 3'd5);

    // Snapshot is {hour,min,sec}, so digit n is simply nibble n
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_digit
            if (gi < NUM_DIGITS) begin : g_used
                assign digit[gi] = snap_reg[gi*4 +: 4];
            end else begin : g_unused
                assign digit[gi] = 4'd0;
            end
        end
    endgenerate

    assign cur_digit = digit[index_reg];
    assign blank     = phase_reg && (blink_sel != BLINK_NONE) &&
                       (blink_sel == field_of_digit(index_reg));

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_an
            if (gi < NUM_DIGITS) begin : g_digit_en
                assign an_next[gi] = !((index_reg == 3'(gi)) && !blank);
            end else begin : g_off
                assign an_next[gi] = 1'b1;
            end
        end
    endgenerate

    bcd_to_seg7 u_dec (
        .bcd (cur_digit),
        .seg (seg_next)
    );

    assign dp_next = !((index_reg == 3'd2) || (index_reg == 3'd4));

    always_ff @(posedge CP) begin
        if (CLR) begin
            pre_reg   <= '0;
            index_reg <= 3'd0;
            frame_reg <= '0;
            phase_reg <= 1'b0;
            snap_reg  <= {hour, min, sec};
            an_reg    <= 8'hFF;
            seg_reg   <= SEG_BLANK;
            dp_reg    <= 1'b1;
        end else begin
            an_reg  <= an_next;
            seg_reg <= seg_next;
            dp_reg  <= dp_next;
            if (tick) begin
                pre_reg   <= '0;
                index_reg <= (index_reg == 3'd5) ? 3'd0 : index_reg + 3'd1;
            end else begin
                pre_reg <= pre_reg + 1'b1;
            end
            // Frame boundary: fresh time for the next frame, advance blink timing
            if (frame_end) begin
                snap_reg <= {hour, min, sec};
                if (frame_reg == FRAME_LAST) begin
                    frame_reg <= '0;
                    phase_reg <= !phase_reg;
                end else begin
                    frame_reg <= frame_reg + 1'b1;
                end
            end
        end
    end

    assign an  = an_reg;
    assign seg = seg_reg;
    assign dp  = dp_reg;

endmodule
